// File: rtl/results_display.sv
// Results display: turns game-core mode/statistics into three seven-segment
// digits, a page indicator and two stretched hit/miss indicator LEDs.
module results_display #(
   parameter int unsigned STRETCH_CYC = 2500000,
   parameter int unsigned PAGE_BEATS  = 8
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic [2:0] mode,
   input  logic       beat_clk,
   input  logic       hit,
   input  logic       missed,
   input  logic [7:0] score,
   input  logic [7:0] num_hits,
   input  logic [7:0] num_misses,
   output logic [6:0] ss_label,
   output logic [6:0] ss_tens,
   output logic [6:0] ss_ones,
   output logic       hit_led,
   output logic       miss_led,
   output logic [1:0] page
);

   localparam int unsigned CW = $clog2(STRETCH_CYC + 1);
   localparam int unsigned BW = (PAGE_BEATS > 1) ? $clog2(PAGE_BEATS) : 1;
   localparam logic [CW-1:0] STRETCH_LD = CW'(STRETCH_CYC);
   localparam logic [BW-1:0] BEAT_LAST  = BW'(PAGE_BEATS - 1);

   localparam logic [2:0] M_PLAY  = 3'b001;
   localparam logic [2:0] M_PAUSE = 3'b010;
   localparam logic [2:0] M_END   = 3'b100;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_PLAY      = 3'd1;
   localparam logic [2:0] S_PAUSE     = 3'd2;
   localparam logic [2:0] S_END_HITS  = 3'd3;
   localparam logic [2:0] S_END_MISS  = 3'd4;
   localparam logic [2:0] S_END_SCORE = 3'd5;

   localparam logic [6:0] SEG_DASH = 7'b1000000;
   localparam logic [6:0] SEG_S    = 7'b1101101;
   localparam logic [6:0] SEG_P    = 7'b1110011;
   localparam logic [6:0] SEG_H    = 7'b1110110;
   localparam logic [6:0] SEG_L    = 7'b0111000;

   logic [2:0]    state, state_next;
   logic          beat_q, beat_rise;
   logic [BW-1:0] beat_cnt, beat_cnt_next;
   logic [7:0]    frozen, frozen_next;
   logic [CW-1:0] hit_cnt, hit_cnt_next, miss_cnt, miss_cnt_next;
   logic [6:0]    label_next;
   logic [7:0]    value_next;
   logic          blank_next;
   logic [1:0]    page_next;

   function automatic logic [6:0] bcd_seg(input logic [3:0] n);
      case (n)
         4'd0:    bcd_seg = 7'b0111111;
         4'd1:    bcd_seg = 7'b0000110;
         4'd2:    bcd_seg = 7'b1011011;
         4'd3:    bcd_seg = 7'b1001111;
         4'd4:    bcd_seg = 7'b1100110;
         4'd5:    bcd_seg = 7'b1101101;
         4'd6:    bcd_seg = 7'b1111101;
         4'd7:    bcd_seg = 7'b0000111;
         4'd8:    bcd_seg = 7'b1111111;
         4'd9:    bcd_seg = 7'b1101111;
         default: bcd_seg = SEG_DASH;
      endcase
   endfunction

   assign beat_rise = beat_clk & ~beat_q;

   // Beat rises are only counted once already in an END state, so a rise on
   // the entry cycle is dropped along with the beat_cnt clear.
   always_comb begin
      state_next    = S_IDLE;
      beat_cnt_next = beat_cnt;
      frozen_next   = frozen;
      case (mode)
         M_PLAY: state_next = S_PLAY;
         M_PAUSE: begin
            if (state == S_PLAY) begin
               state_next  = S_PAUSE;
               frozen_next = score;
            end else if (state == S_PAUSE) begin
               state_next = S_PAUSE;
            end
         end
         M_END: begin
            case (state)
               S_PLAY, S_PAUSE: begin
                  state_next    = S_END_HITS;
                  beat_cnt_next = '0;
               end
               S_END_HITS, S_END_MISS, S_END_SCORE: begin
                  state_next = state;
                  if (beat_rise) begin
                     if (beat_cnt == BEAT_LAST) begin
                        beat_cnt_next = '0;
                        case (state)
                           S_END_HITS: state_next = S_END_MISS;
                           S_END_MISS: state_next = S_END_SCORE;
                           default:    state_next = S_END_HITS;
                        endcase
                     end else begin
                        beat_cnt_next = beat_cnt + BW'(1);
                     end
                  end
               end
               default: state_next = S_IDLE;
            endcase
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      label_next = SEG_DASH;
      value_next = score;
      blank_next = 1'b0;
      page_next  = 2'd0;
      case (state_next)
         S_PLAY: label_next = SEG_S;
         S_PAUSE: begin
            label_next = SEG_P;
            value_next = frozen_next;
         end
         S_END_HITS: begin
            label_next = SEG_H;
            value_next = num_hits;
            page_next  = 2'd1;
         end
         S_END_MISS: begin
            label_next = SEG_L;
            value_next = num_misses;
            page_next  = 2'd2;
         end
         S_END_SCORE: begin
            label_next = SEG_S;
            page_next  = 2'd3;
         end
         default: blank_next = 1'b1;
      endcase
   end

   always_comb begin
      hit_cnt_next  = '0;
      miss_cnt_next = '0;
      if (state_next == S_PLAY) begin
         if (hit)
            hit_cnt_next = STRETCH_LD;
         else if (hit_cnt != '0)
            hit_cnt_next = hit_cnt - CW'(1);
         if (missed)
            miss_cnt_next = STRETCH_LD;
         else if (miss_cnt != '0)
            miss_cnt_next = miss_cnt - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state    <= S_IDLE;
         beat_q   <= 1'b0;
         beat_cnt <= '0;
         frozen   <= '0;
         hit_cnt  <= '0;
         miss_cnt <= '0;
         ss_label <= SEG_DASH;
         ss_tens  <= SEG_DASH;
         ss_ones  <= SEG_DASH;
         hit_led  <= 1'b0;
         miss_led <= 1'b0;
         page     <= 2'd0;
      end else begin
         state    <= state_next;
         beat_q   <= beat_clk;
         beat_cnt <= beat_cnt_next;
         frozen   <= frozen_next;
         hit_cnt  <= hit_cnt_next;
         miss_cnt <= miss_cnt_next;
         ss_label <= label_next;
         ss_tens  <= blank_next ? SEG_DASH : bcd_seg(value_next[7:4]);
         ss_ones  <= blank_next ? SEG_DASH : bcd_seg(value_next[3:0]);
         hit_led  <= (hit_cnt_next != '0);
         miss_led <= (miss_cnt_next != '0);
         page     <= page_next;
      end
   end

endmodule

// File: tb/tb_results_display.sv
// Bench for results_display: directed scenarios plus random traffic checked
// cycle by cycle against an event-level reference model.
module tb_results_display;

   localparam int STRETCH = 5;
   localparam int PB      = 2;

   logic       clk = 1'b0;
   logic       n_rst;
   logic [2:0] mode;
   logic       beat_clk, hit, missed;
   logic [7:0] score, num_hits, num_misses;
   logic [6:0] ss_label, ss_tens, ss_ones;
   logic       hit_led, miss_led;
   logic [1:0] page;

   always #5 clk = ~clk;

   results_display #(.STRETCH_CYC(STRETCH), .PAGE_BEATS(PB)) dut (
      .clk(clk), .n_rst(n_rst), .mode(mode), .beat_clk(beat_clk),
      .hit(hit), .missed(missed), .score(score), .num_hits(num_hits),
      .num_misses(num_misses), .ss_label(ss_label), .ss_tens(ss_tens),
      .ss_ones(ss_ones), .hit_led(hit_led), .miss_led(miss_led), .page(page)
   );

   int tests = 0;
   int fails = 0;

   logic [6:0] seg_tab [0:9] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                  7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                                  7'b1111111, 7'b1101111};

   // Model: game phase 0 idle, 1 play, 2 pause, 3 end; in end the page is
   // derived from the number of beat rises seen since entering.
   int   gs, frozen, rises, k, hit_last, miss_last;
   bit   prev_beat, hit_on, miss_on;

   function automatic logic [6:0] seg(input logic [3:0] n);
      return (n > 9) ? 7'b1000000 : seg_tab[n];
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      gs = 0; frozen = 0; rises = 0; prev_beat = 0; hit_on = 0; miss_on = 0;
   endtask

   task automatic model_edge();
      bit rise;
      rise = beat_clk && !prev_beat;
      prev_beat = beat_clk;
      k++;
      case (mode)
         3'b001: gs = 1;
         3'b010: begin
            if (gs == 1) begin gs = 2; frozen = score; end
            else if (gs != 2) gs = 0;
         end
         3'b100: begin
            if (gs == 1 || gs == 2) begin gs = 3; rises = 0; end
            else if (gs == 3) begin if (rise) rises++; end
            else gs = 0;
         end
         default: gs = 0;
      endcase
      if (gs == 1) begin
         if (hit)    begin hit_on = 1;  hit_last = k;  end
         if (missed) begin miss_on = 1; miss_last = k; end
      end else begin
         hit_on = 0; miss_on = 0;
      end
   endtask

   task automatic check_all();
      logic [6:0] lab;
      logic [7:0] v;
      bit blank;
      int pg;
      blank = 0; v = score; pg = 0; lab = 7'b1000000;
      case (gs)
         1: lab = 7'b1101101;
         2: begin lab = 7'b1110011; v = frozen[7:0]; end
         3: begin
            pg = (rises / PB) % 3 + 1;
            if (pg == 1)      begin lab = 7'b1110110; v = num_hits; end
            else if (pg == 2) begin lab = 7'b0111000; v = num_misses; end
            else              lab = 7'b1101101;
         end
         default: blank = 1;
      endcase
      check("label", ss_label, lab);
      check("tens",  ss_tens,  blank ? 7'b1000000 : seg(v[7:4]));
      check("ones",  ss_ones,  blank ? 7'b1000000 : seg(v[3:0]));
      check("page",  page,     pg);
      check("hit_led",  hit_led,  hit_on  && (k - hit_last  < STRETCH));
      check("miss_led", miss_led, miss_on && (k - miss_last < STRETCH));
   endtask

   // Called at a negedge; returns at the next negedge with outputs checked.
   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         if (n_rst) model_edge();
         #1 check_all();
         @(negedge clk);
      end
   endtask

   function automatic logic [2:0] pick_mode();
      int r;
      r = $urandom_range(0, 9);
      if (r < 4) return 3'b001;
      if (r < 6) return 3'b010;
      if (r < 9) return 3'b100;
      return 3'($urandom_range(0, 7));
   endfunction

   initial begin
      k = 0; hit_last = 0; miss_last = 0;
      model_reset();
      n_rst = 1'b1; mode = 3'b001; beat_clk = 0; hit = 0; missed = 0;
      score = 8'h42; num_hits = 8'h23; num_misses = 8'h08;
      #2 n_rst = 1'b0;
      #1 check_all();
      @(negedge clk);
      step(2);
      n_rst = 1'b1;
      step(1);
      check("post_rst_label", ss_label, 7'b1101101);
      check("post_rst_tens",  ss_tens,  7'b1100110);
      check("post_rst_ones",  ss_ones,  7'b1011011);

      // hit pulse, retrigger, and simultaneous hit/miss
      hit = 1; step(1); hit = 0; step(2);
      hit = 1; step(1); hit = 0; step(7);
      hit = 1; missed = 1; step(1); hit = 0; missed = 0; step(6);

      // freeze on pause, then end mode
      score = 8'h17; step(2);
      mode = 3'b010; step(1);
      score = 8'h99; step(3);
      check("pause_tens", ss_tens, 7'b0000110);
      mode = 3'b100; beat_clk = 1; step(1);
      check("end_entry_page", page, 2'd1);

      // page cycling, then beat held high
      for (int i = 0; i < 14; i++) begin beat_clk = ~beat_clk; step(2); end
      beat_clk = 1; step(10);

      // invalid BCD nibble and forced idle with a lit LED
      mode = 3'b001; score = 8'h5A; step(1);
      check("bcd_dash_ones", ss_ones, 7'b1000000);
      hit = 1; step(1); hit = 0; step(1);
      mode = 3'b111; step(1);
      check("idle_hit_led", hit_led, 1'b0);
      step(2);

      // async reset while showing the misses page
      mode = 3'b001; step(2);
      mode = 3'b100; beat_clk = 0; step(1);
      for (int i = 0; i < 4; i++) begin beat_clk = ~beat_clk; step(1); end
      check("end_miss_page", page, 2'd2);
      #2 n_rst = 1'b0;
      #1 model_reset();
      check_all();
      @(negedge clk);
      step(2);
      n_rst = 1'b1;
      step(3);
      check("rst_end_stays_idle", page, 2'd0);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 11) == 0) mode = pick_mode();
         if ($urandom_range(0, 2) == 0) beat_clk = ~beat_clk;
         hit    = ($urandom_range(0, 9) == 0);
         missed = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 7) == 0) score = 8'($urandom);
         if ($urandom_range(0, 15) == 0) num_hits = 8'($urandom);
         if ($urandom_range(0, 15) == 0) num_misses = 8'($urandom);
         step(1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
